// File: rtl/rf_port_master_if.sv
// rf_port_master_if: bundles the command channel, the register-file ports, the read-response
// channel and the status flags of rf_port_master.
//   master : view taken by rf_port_master (drives cmd_ready, rf_*, rsp_*, busy, err)
//   slave  : view taken by the upstream / register-file side
// Parameters: DW data width, AW address width (2^AW register-file entries).
interface rf_port_master_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 3
) ();
    // command channel
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;
    logic [DW-1:0] cmd_wdata;
    // register-file ports
    logic [AW-1:0] rf_wAddr;
    logic [DW-1:0] rf_wData;
    logic          rf_we;
    logic [AW-1:0] rf_rAddr;
    logic [DW-1:0] rf_rData;
    // read-response channel
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;
    logic          rsp_last;
    // status
    logic          busy;
    logic          err;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_wdata, rf_rData, rsp_ready,
        output cmd_ready, rf_wAddr, rf_wData, rf_we, rf_rAddr,
        output rsp_valid, rsp_data, rsp_addr, rsp_last, busy, err
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_wdata, rf_rData, rsp_ready,
        input  cmd_ready, rf_wAddr, rf_wData, rf_we, rf_rAddr,
        input  rsp_valid, rsp_data, rsp_addr, rsp_last, busy, err
    );
endinterface

// File: rtl/rf_port_master.sv
// rf_port_master: command-driven initiator for a 2^AW x DW register file.
// Accepts single/burst read or write commands (valid/ready), sequences them onto the
// register-file write and read ports, and returns read beats over a valid/ready channel.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : rf_port_master_if.master (command, register-file ports, response, busy/err)
// Optional feature: define RF_MASTER_READBACK_EN to follow every write beat with a readback
// (CHK) cycle that sets the sticky err flag when the file returns something else.
module rf_port_master #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 3
) (
    input logic               clk,
    input logic               reset,
    rf_port_master_if.master  bus
);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StChk,
        StRd,
        StRsp
    } state_e;

    localparam logic [AW-1:0] One = {{(AW-1){1'b0}}, 1'b1};

    state_e        state_q, state_d;
    logic [AW-1:0] len_q, len_d;
    logic [AW-1:0] beat_q, beat_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic [AW-1:0] rsp_addr_q, rsp_addr_d;
    logic          rsp_last_q, rsp_last_d;
`ifdef RF_MASTER_READBACK_EN
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        beat_d     = beat_q;
        waddr_d    = waddr_q;
        raddr_d    = raddr_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        rsp_addr_d = rsp_addr_q;
        rsp_last_d = rsp_last_q;
`ifdef RF_MASTER_READBACK_EN
        err_d      = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    len_d   = bus.cmd_len;
                    beat_d  = '0;
                    wdata_d = bus.cmd_wdata;
                    if (bus.cmd_write) begin
                        waddr_d = bus.cmd_addr;
                        state_d = StWr;
                    end else begin
                        raddr_d = bus.cmd_addr;
                        state_d = StRd;
                    end
                end
            end
            StWr: begin
`ifdef RF_MASTER_READBACK_EN
                // point the read port at the entry being written so CHK sees it next cycle
                raddr_d = waddr_q;
                state_d = StChk;
`else
                if (beat_q == len_q) begin
                    state_d = StIdle;
                end else begin
                    beat_d  = beat_q + One;
                    waddr_d = waddr_q + One;
                end
`endif
            end
            StChk: begin
`ifdef RF_MASTER_READBACK_EN
                if (bus.rf_rData != wdata_q) begin
                    err_d = 1'b1;
                end
                if (beat_q == len_q) begin
                    state_d = StIdle;
                end else begin
                    beat_d  = beat_q + One;
                    waddr_d = waddr_q + One;
                    state_d = StWr;
                end
`else
                state_d = StIdle;
`endif
            end
            StRd: begin
                rsp_data_d = bus.rf_rData;
                rsp_addr_d = raddr_q;
                rsp_last_d = (beat_q == len_q);
                state_d    = StRsp;
            end
            StRsp: begin
                // rsp_* registers only change in StRd, so they hold through any stall
                if (bus.rsp_ready) begin
                    if (rsp_last_q) begin
                        state_d = StIdle;
                    end else begin
                        beat_d  = beat_q + One;
                        raddr_d = raddr_q + One;
                        state_d = StRd;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            len_q      <= '0;
            beat_q     <= '0;
            waddr_q    <= '0;
            raddr_q    <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_addr_q <= '0;
            rsp_last_q <= 1'b0;
`ifdef RF_MASTER_READBACK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_last_q <= rsp_last_d;
`ifdef RF_MASTER_READBACK_EN
            err_q      <= err_d;
`endif
        end
    end

    // Every output is a flop or a decode of state_q.
    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.rf_we     = (state_q == StWr);
    assign bus.rf_wAddr  = waddr_q;
    assign bus.rf_wData  = wdata_q;
    assign bus.rf_rAddr  = raddr_q;
    assign bus.rsp_valid = (state_q == StRsp);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_last  = rsp_last_q;
`ifdef RF_MASTER_READBACK_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif

endmodule
